id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV64 core, directly downstream of the

---
 rtl/id_ex_stage_reg.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush squash
// and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic             id_Branch,
    input  logic             id_MemRead,
    input  logic             id_MemtoReg,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic             id_RegWrite,
    input  logic [1:0]       id_ALUOp,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    output logic             ex_valid,
    output logic             ex_Branch,
    output logic             ex_MemRead,
    output logic             ex_MemtoReg,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic             ex_RegWrite,
    output logic [1:0]       ex_ALUOp,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Control bundle order: {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0]}
    logic [7:0]       w_id_ctrl;
    logic [7:0]       r_ctrl;
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [3:0]       r_funct;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_uses_rs1;
    logic w_uses_rs2;
    logic w_ex_is_load;
    logic w_load_use;
    logic w_bubble;

    assign w_id_ctrl = {id_Branch, id_MemRead, id_MemtoReg, id_MemWrite,
                        id_ALUSrc, id_RegWrite, id_ALUOp};

    always_comb begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        case (id_opcode)
            OP_LUI, OP_AUIPC, OP_JAL:     w_uses_rs1 = 1'b0;
            OP_REG, OP_STORE, OP_BRANCH:  w_uses_rs2 = 1'b1;
            default: ;
        endcase
    end

    // MemtoReg qualifies MemRead: OP-IMM also raises MemRead and must not stall.
    assign w_ex_is_load = r_valid & r_ctrl[6] & r_ctrl[5];

    assign w_load_use = w_ex_is_load & id_valid & (r_rd != 5'd0) &
                        ((w_uses_rs1 & (r_rd == id_rs1)) |
                         (w_uses_rs2 & (r_rd == id_rs2)));

    assign stall    = w_load_use & ~flush;
    assign w_bubble = flush | w_load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_funct      <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid    <= 1'b0;
                r_ctrl     <= '0;
                r_pc       <= '0;
                r_rs1_data <= '0;
                r_rs2_data <= '0;
                r_imm      <= '0;
                r_rs1      <= '0;
                r_rs2      <= '0;
                r_rd       <= '0;
                r_funct    <= '0;
            end else begin
                // A load-use bubble still captures the held operands; only control is squashed.
                r_valid    <= id_valid & ~w_load_use;
                r_ctrl     <= (w_load_use | ~id_valid) ? 8'd0 : w_id_ctrl;
                r_pc       <= id_pc;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm      <= id_imm;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
                r_funct    <= id_funct;
            end
            if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign ex_valid    = r_valid;
    assign ex_Branch   = r_ctrl[7];
    assign ex_MemRead  = r_ctrl[6];
    assign ex_MemtoReg = r_ctrl[5];
    assign ex_MemWrite = r_ctrl[4];
    assign ex_ALUSrc   = r_ctrl[3];
    assign ex_RegWrite = r_ctrl[2];
    assign ex_ALUOp    = r_ctrl[1:0];
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_funct    = r_funct;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: hazard stall, bubble insertion, flush
// priority and counter saturation (second instance with a 2-bit counter).
module tb_id_ex_stage_reg;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, id_valid;
    logic [6:0]       id_opcode;
    logic             id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [1:0]       id_ALUOp;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [3:0]       id_funct;

    logic             ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [1:0]       ex_ALUOp;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_funct;
    logic             stall;
    logic [15:0]      bubble_cnt;

    logic             s_valid, s_Branch, s_MemRead, s_MemtoReg, s_MemWrite, s_ALUSrc, s_RegWrite;
    logic [1:0]       s_ALUOp;
    logic [XLEN-1:0]  s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]       s_rs1, s_rs2, s_rd;
    logic [3:0]       s_funct;
    logic             s_stall;
    logic [1:0]       s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .ex_valid(ex_valid), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
        .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .ex_valid(s_valid), .ex_Branch(s_Branch), .ex_MemRead(s_MemRead),
        .ex_MemtoReg(s_MemtoReg), .ex_MemWrite(s_MemWrite), .ex_ALUSrc(s_ALUSrc),
        .ex_RegWrite(s_RegWrite), .ex_ALUOp(s_ALUOp), .ex_pc(s_pc),
        .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
        .stall(s_stall), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One decoded instruction presented to ID; operand data is derived from pc.
    task automatic drv(input logic v, input logic [6:0] op, input logic mr, input logic m2r,
                       input logic mw, input logic alusrc, input logic rw, input logic [1:0] aluop,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [63:0] pc);
        id_valid    = v;
        id_opcode   = op;
        id_Branch   = 1'b0;
        id_MemRead  = mr;
        id_MemtoReg = m2r;
        id_MemWrite = mw;
        id_ALUSrc   = alusrc;
        id_RegWrite = rw;
        id_ALUOp    = aluop;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_funct    = 4'h3;
        id_pc       = pc;
        id_rs1_data = pc ^ 64'hA5A5_0000_0000_1111;
        id_rs2_data = pc ^ 64'h5A5A_0000_0000_2222;
        id_imm      = pc + 64'd8;
        $display("step pc=%h op=%b rs1=%0d rs2=%0d rd=%0d flush=%0b", pc, op, rs1, rs2, rd, flush);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        // Reset with nonzero inputs held for two edges.
        drv(1'b1, 7'b0000011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd5, 64'h1000);
        tick();
        tick();
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_regwrite", ex_RegWrite, 1'b0);
        chk("rst_memread", ex_MemRead, 1'b0);
        chk("rst_pc", ex_pc, 64'h0);
        chk("rst_rd", ex_rd, 5'd0);
        chk("rst_imm", ex_imm, 64'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_cnt", bubble_cnt, 16'd0);

        // ld x5 -> add x6,x5,x7: one-cycle stall then the add.
        reset = 1'b0;
        drv(1'b1, 7'b0000011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd0, 5'd5, 64'h100);
        #1 chk("ld_nostall", stall, 1'b0);
        tick();
        chk("ld_valid", ex_valid, 1'b1);
        chk("ld_memread", ex_MemRead, 1'b1);
        chk("ld_rd", ex_rd, 5'd5);
        chk("ld_pc", ex_pc, 64'h100);
        drv(1'b1, 7'b0110011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd5, 5'd7, 5'd6, 64'h104);
        #1 chk("lu_stall", stall, 1'b1);
        tick();
        chk("bub_valid", ex_valid, 1'b0);
        chk("bub_regwrite", ex_RegWrite, 1'b0);
        chk("bub_aluop", ex_ALUOp, 2'b00);
        chk("bub_pc", ex_pc, 64'h104);
        chk("bub_cnt", bubble_cnt, 16'd1);
        chk("bub_stall_clear", stall, 1'b0);
        tick();
        chk("add_valid", ex_valid, 1'b1);
        chk("add_rs1", ex_rs1, 5'd5);
        chk("add_regwrite", ex_RegWrite, 1'b1);
        chk("add_aluop", ex_ALUOp, 2'b10);
        chk("add_funct", ex_funct, 4'h3);
        chk("add_cnt", bubble_cnt, 16'd1);

        // addi x5 (MemRead=1, MemtoReg=0) -> add x6,x5,x5: no stall.
        drv(1'b1, 7'b0010011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 5'd1, 5'd0, 5'd5, 64'h108);
        tick();
        chk("addi_memread", ex_MemRead, 1'b1);
        chk("addi_memtoreg", ex_MemtoReg, 1'b0);
        drv(1'b1, 7'b0110011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd5, 5'd5, 5'd6, 64'h10C);
        #1 chk("addi_nostall", stall, 1'b0);
        tick();
        chk("addi_add_valid", ex_valid, 1'b1);
        chk("addi_cnt", bubble_cnt, 16'd1);

        // ld x0 -> add x6,x0,x0: no stall.
        drv(1'b1, 7'b0000011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd0, 5'd0, 64'h110);
        tick();
        drv(1'b1, 7'b0110011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 5'd0, 5'd6, 64'h114);
        #1 chk("ldx0_nostall", stall, 1'b0);
        tick();
        chk("ldx0_valid", ex_valid, 1'b1);

        // ld x5 -> lui x5 (rs fields happen to hold 5): no stall.
        drv(1'b1, 7'b0000011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd2, 5'd0, 5'd5, 64'h118);
        tick();
        drv(1'b1, 7'b0110111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd5, 5'd5, 5'd5, 64'h11C);
        #1 chk("lui_nostall", stall, 1'b0);
        tick();
        chk("lui_valid", ex_valid, 1'b1);
        chk("lui_rd", ex_rd, 5'd5);
        chk("lui_cnt", bubble_cnt, 16'd1);

        // ld x5 -> sd x5,0(x2) with MemtoReg=X: stall via rs2; X must not leak into stall later.
        drv(1'b1, 7'b0000011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd2, 5'd0, 5'd5, 64'h120);
        tick();
        drv(1'b1, 7'b0100011, 1'b0, 1'bx, 1'b1, 1'b1, 1'b0, 2'b00, 5'd2, 5'd5, 5'd6, 64'h124);
        #1 chk("sd_stall", stall, 1'b1);
        tick();
        chk("sd_bub_valid", ex_valid, 1'b0);
        chk("sd_bub_cnt", bubble_cnt, 16'd2);
        tick();
        chk("sd_valid", ex_valid, 1'b1);
        chk("sd_memwrite", ex_MemWrite, 1'b1);
        drv(1'b1, 7'b0110011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd6, 5'd6, 5'd7, 64'h128);
        #1 chk("sd_x_nostall", stall, 1'b0);
        tick();

        // Invalid slot: control forced to 0, data still captured.
        drv(1'b0, 7'b0110011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd3, 5'd4, 5'd9, 64'h12C);
        tick();
        chk("inv_valid", ex_valid, 1'b0);
        chk("inv_regwrite", ex_RegWrite, 1'b0);
        chk("inv_pc", ex_pc, 64'h12C);
        chk("inv_cnt", bubble_cnt, 16'd2);

        // load_use and flush together: flush wins, counted once.
        drv(1'b1, 7'b0000011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd0, 5'd5, 64'h130);
        tick();
        flush = 1'b1;
        drv(1'b1, 7'b0110011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd5, 5'd7, 5'd6, 64'h134);
        #1 chk("fl_stall", stall, 1'b0);
        tick();
        chk("fl_valid", ex_valid, 1'b0);
        chk("fl_regwrite", ex_RegWrite, 1'b0);
        chk("fl_memread", ex_MemRead, 1'b0);
        chk("fl_pc", ex_pc, 64'h0);
        chk("fl_rs1", ex_rs1, 5'd0);
        chk("fl_cnt", bubble_cnt, 16'd3);
        flush = 1'b0;
        #1 chk("fl_after_stall", stall, 1'b0);
        tick();
        chk("fl_next_valid", ex_valid, 1'b1);
        chk("fl_next_rs1", ex_rs1, 5'd5);
        chk("fl_next_pc", ex_pc, 64'h134);
        chk("fl_next_cnt", bubble_cnt, 16'd3);

        // Reset overrides flush, then five flushes saturate the 2-bit counter.
        reset = 1'b1;
        flush = 1'b1;
        tick();
        chk("rstfl_cnt", bubble_cnt, 16'd0);
        chk("rstfl_cnt_sat", s_bubble_cnt, 2'd0);
        reset = 1'b0;
        tick();
        chk("sat_1", s_bubble_cnt, 2'd1);
        chk("wide_1", bubble_cnt, 16'd1);
        tick();
        chk("sat_2", s_bubble_cnt, 2'd2);
        tick();
        chk("sat_3", s_bubble_cnt, 2'd3);
        tick();
        chk("sat_4", s_bubble_cnt, 2'd3);
        tick();
        chk("sat_5", s_bubble_cnt, 2'd3);
        chk("wide_5", bubble_cnt, 16'd5);
        chk("sat_flush_valid", s_valid, 1'b0);
        flush = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
